regfile_scoreboard: RTL and testbench

Parametrised register file and scoreboard for the decode stage. It holds the architectural scalar registers, tracks in-flight writes with per-register pending counters instead of single valid bits, and accepts writes from several writeback ports per cycle. Each cycle it reports a data-dependency stall, forwards same-cycle writeback data, and registers operand values toward execute. It replaces the split posedge-write / negedge-read scheme with a single rising-edge design.

---
 rtl/regfile_scoreboard_pkg.sv | 29 ++
 rtl/regfile_scoreboard_pending_counter.sv | 53 +++++
 rtl/regfile_scoreboard.sv | 189 ++++++++++++++++++
 tb/tb_regfile_scoreboard.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared definitions for the decode-stage register file / scoreboard.
package regfile_scoreboard_pkg;

  localparam int unsigned REG_WIDTH_D = 32;
  localparam int unsigned NUM_REGS_D  = 16;
  localparam int unsigned IDXW_D      = $clog2(NUM_REGS_D);

  // NZP condition-code encodings
  localparam logic [2:0] CC_NONE = 3'b000;
  localparam logic [2:0] CC_N    = 3'b100;
  localparam logic [2:0] CC_Z    = 3'b010;
  localparam logic [2:0] CC_P    = 3'b001;

  // One writeback port at the default geometry
  typedef struct packed {
    logic                   en;
    logic [IDXW_D-1:0]      idx;
    logic [REG_WIDTH_D-1:0] data;
    logic                   set_cc;
  } wb_port_t;

  // Sign wins over zero; a value with the sign bit set is never zero anyway
  function automatic logic [2:0] cc_encode(input logic sign, input logic zero);
    if (sign)      return CC_N;
    else if (zero) return CC_Z;
    else           return CC_P;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_pending_counter.sv
// Saturating in-flight write counter: one increment and up to NUM_WB
// decrements per cycle; an attempted drop below zero is flagged.
module pending_counter
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 2,
  parameter int unsigned NUM_WB    = 2
) (
  input  logic                 I_CLOCK,
  input  logic                 I_RESET,
  input  logic                 inc,
  input  logic [NUM_WB-1:0]    dec,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 next_zero,
  output logic                 full,
  output logic                 underflow
);

  localparam int unsigned EW = CNT_WIDTH + $clog2(NUM_WB + 1) + 1;

  logic [EW-1:0]        ndec;
  logic [EW-1:0]        cnt_ext;
  logic [EW-1:0]        avail;
  logic [CNT_WIDTH-1:0] next_cnt;

  assign cnt_ext = EW'(count);

  // Number of writebacks retiring against this counter this cycle
  always_comb begin
    ndec = '0;
    for (int unsigned p = 0; p < NUM_WB; p++) begin
      ndec = ndec + EW'(dec[p]);
    end
  end

  // Drain test ignores the increment so issue readiness never depends on accept
  assign next_zero = (cnt_ext <= ndec);
  assign full      = &count;

  // Net update with saturation at zero
  always_comb begin
    avail     = cnt_ext + EW'(inc);
    underflow = (avail < ndec);
    next_cnt  = underflow ? '0 : CNT_WIDTH'(avail - ndec);
  end

  // Counter state
  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) count <= '0;
    else         count <= next_cnt;
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with per-register pending counters,
// multi-port writeback, same-cycle bypass and registered operands.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter  int unsigned NUM_REGS  = NUM_REGS_D,
  parameter  int unsigned REG_WIDTH = REG_WIDTH_D,
  parameter  int unsigned NUM_WB    = 2,
  parameter  int unsigned CNT_WIDTH = 2,
  localparam int unsigned IDXW      = $clog2(NUM_REGS)
) (
  input  logic                        I_CLOCK,
  input  logic                        I_RESET,
  input  logic                        I_LOCK,
  input  logic                        I_IssueValid,
  input  logic                        I_Src1Used,
  input  logic                        I_Src2Used,
  input  logic [IDXW-1:0]             I_Src1Idx,
  input  logic [IDXW-1:0]             I_Src2Idx,
  input  logic                        I_DestValid,
  input  logic [IDXW-1:0]             I_DestIdx,
  input  logic                        I_CCUsed,
  input  logic                        I_CCSet,
  input  logic [NUM_WB-1:0]           I_WbEnable,
  input  logic [NUM_WB*IDXW-1:0]      I_WbIdx,
  input  logic [NUM_WB*REG_WIDTH-1:0] I_WbData,
  input  logic [NUM_WB-1:0]           I_WbSetCC,
  output logic                        O_DepStall,
  output logic                        O_Valid,
  output logic [REG_WIDTH-1:0]        O_Src1Value,
  output logic [REG_WIDTH-1:0]        O_Src2Value,
  output logic [2:0]                  O_CC,
  output logic                        O_WbError
);

  logic [REG_WIDTH-1:0] rf [NUM_REGS];
  logic [IDXW-1:0]      wb_idx [NUM_WB];
  logic [REG_WIDTH-1:0] wb_data [NUM_WB];
  logic [NUM_WB-1:0]    dec_match [NUM_REGS];

  logic [NUM_REGS-1:0]  inc_vec;
  logic [NUM_REGS-1:0]  ready_vec;
  logic [NUM_REGS-1:0]  full_vec;
  logic [NUM_REGS-1:0]  uflow_vec;
  logic [CNT_WIDTH-1:0] pend_count_unused [NUM_REGS];

  logic                 cc_inc;
  logic                 cc_drained;
  logic                 cc_uflow;
  logic                 cc_full_unused;
  logic [CNT_WIDTH-1:0] cc_count_unused;

  logic                 src1_ready;
  logic                 src2_ready;
  logic                 cc_ready;
  logic                 dest_blocked;
  logic                 accept;
  logic [REG_WIDTH-1:0] src1_val;
  logic [REG_WIDTH-1:0] src2_val;
  logic                 cc_wr;
  logic [2:0]           cc_next;

  // Split the flattened writeback buses into per-port fields
  always_comb begin
    for (int unsigned p = 0; p < NUM_WB; p++) begin
      wb_idx[p]  = I_WbIdx[p*IDXW +: IDXW];
      wb_data[p] = I_WbData[p*REG_WIDTH +: REG_WIDTH];
    end
  end

  // Per-register vector of enabled writeback ports targeting it
  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      for (int unsigned p = 0; p < NUM_WB; p++) begin
        dec_match[r][p] = I_WbEnable[p] && (wb_idx[p] == IDXW'(r));
      end
    end
  end

  assign src1_ready   = !I_Src1Used || ready_vec[I_Src1Idx];
  assign src2_ready   = !I_Src2Used || ready_vec[I_Src2Idx];
  assign cc_ready     = !I_CCUsed || cc_drained;
  assign dest_blocked = I_DestValid && full_vec[I_DestIdx] && !(|dec_match[I_DestIdx]);

  assign O_DepStall = I_LOCK && I_IssueValid &&
                      (!src1_ready || !src2_ready || !cc_ready || dest_blocked);
  assign accept     = I_LOCK && I_IssueValid && !O_DepStall;
  assign cc_inc     = accept && I_CCSet;

  // Destination claim for the accepted instruction
  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      inc_vec[r] = accept && I_DestValid && (I_DestIdx == IDXW'(r));
    end
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_pend
    pending_counter #(
      .CNT_WIDTH (CNT_WIDTH),
      .NUM_WB    (NUM_WB)
    ) u_pend (
      .I_CLOCK   (I_CLOCK),
      .I_RESET   (I_RESET),
      .inc       (inc_vec[r]),
      .dec       (dec_match[r]),
      .count     (pend_count_unused[r]),
      .next_zero (ready_vec[r]),
      .full      (full_vec[r]),
      .underflow (uflow_vec[r])
    );
  end

  pending_counter #(
    .CNT_WIDTH (CNT_WIDTH),
    .NUM_WB    (NUM_WB)
  ) u_cc_pend (
    .I_CLOCK   (I_CLOCK),
    .I_RESET   (I_RESET),
    .inc       (cc_inc),
    .dec       (I_WbSetCC),
    .count     (cc_count_unused),
    .next_zero (cc_drained),
    .full      (cc_full_unused),
    .underflow (cc_uflow)
  );

  // Operand read: highest-numbered matching writeback overrides the RF
  always_comb begin
    src1_val = rf[I_Src1Idx];
    src2_val = rf[I_Src2Idx];
    for (int unsigned p = 0; p < NUM_WB; p++) begin
      if (I_WbEnable[p] && (wb_idx[p] == I_Src1Idx)) src1_val = wb_data[p];
      if (I_WbEnable[p] && (wb_idx[p] == I_Src2Idx)) src2_val = wb_data[p];
    end
  end

  // Condition code from the highest-numbered CC-retiring port
  always_comb begin
    cc_wr   = 1'b0;
    cc_next = O_CC;
    for (int unsigned p = 0; p < NUM_WB; p++) begin
      if (I_WbSetCC[p]) begin
        cc_wr   = 1'b1;
        cc_next = cc_encode(wb_data[p][REG_WIDTH-1], wb_data[p] == '0);
      end
    end
  end

  // Register write: later ports overwrite earlier ones, so the highest wins
  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) rf[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        for (int unsigned p = 0; p < NUM_WB; p++) begin
          if (dec_match[r][p]) rf[r] <= wb_data[p];
        end
      end
    end
  end

  // Operand capture toward execute; values hold when nothing issues
  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      O_Valid     <= 1'b0;
      O_Src1Value <= '0;
      O_Src2Value <= '0;
    end else begin
      O_Valid <= accept;
      if (accept) begin
        O_Src1Value <= src1_val;
        O_Src2Value <= src2_val;
      end
    end
  end

  // Condition-code register
  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET)    O_CC <= CC_NONE;
    else if (cc_wr) O_CC <= cc_next;
  end

  // Sticky flag for writebacks that found nothing pending
  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET)                       O_WbError <= 1'b0;
    else if ((|uflow_vec) || cc_uflow) O_WbError <= 1'b1;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: expected operands are queued when an accepted issue
// is driven and compared when O_Valid appears one cycle later.
module tb_regfile_scoreboard;
  import regfile_scoreboard_pkg::*;

  localparam int unsigned NW = 2;

  logic           I_CLOCK = 1'b0;
  logic           I_RESET;
  logic           I_LOCK;
  logic           I_IssueValid;
  logic           I_Src1Used, I_Src2Used;
  logic [3:0]     I_Src1Idx, I_Src2Idx;
  logic           I_DestValid;
  logic [3:0]     I_DestIdx;
  logic           I_CCUsed, I_CCSet;
  logic [NW-1:0]  I_WbEnable;
  logic [NW*4-1:0]  I_WbIdx;
  logic [NW*32-1:0] I_WbData;
  logic [NW-1:0]  I_WbSetCC;
  logic           O_DepStall, O_Valid, O_WbError;
  logic [31:0]    O_Src1Value, O_Src2Value;
  logic [2:0]     O_CC;

  wb_port_t wb [NW];

  typedef struct {
    logic [31:0] s1;
    logic [31:0] s2;
  } exp_t;

  exp_t exp_q [$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en   = 1'b0;

  regfile_scoreboard #(
    .NUM_REGS  (16),
    .REG_WIDTH (32),
    .NUM_WB    (NW),
    .CNT_WIDTH (2)
  ) dut (
    .I_CLOCK      (I_CLOCK),
    .I_RESET      (I_RESET),
    .I_LOCK       (I_LOCK),
    .I_IssueValid (I_IssueValid),
    .I_Src1Used   (I_Src1Used),
    .I_Src2Used   (I_Src2Used),
    .I_Src1Idx    (I_Src1Idx),
    .I_Src2Idx    (I_Src2Idx),
    .I_DestValid  (I_DestValid),
    .I_DestIdx    (I_DestIdx),
    .I_CCUsed     (I_CCUsed),
    .I_CCSet      (I_CCSet),
    .I_WbEnable   (I_WbEnable),
    .I_WbIdx      (I_WbIdx),
    .I_WbData     (I_WbData),
    .I_WbSetCC    (I_WbSetCC),
    .O_DepStall   (O_DepStall),
    .O_Valid      (O_Valid),
    .O_Src1Value  (O_Src1Value),
    .O_Src2Value  (O_Src2Value),
    .O_CC         (O_CC),
    .O_WbError    (O_WbError)
  );

  always #5 I_CLOCK = ~I_CLOCK;

  // Pack the per-port stimulus records onto the flat buses
  always_comb begin
    for (int p = 0; p < NW; p++) begin
      I_WbEnable[p]       = wb[p].en;
      I_WbIdx[p*4 +: 4]   = wb[p].idx;
      I_WbData[p*32 +: 32] = wb[p].data;
      I_WbSetCC[p]        = wb[p].set_cc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input bit iv, input bit s1u, input logic [3:0] s1,
                       input bit s2u, input logic [3:0] s2,
                       input bit dv, input logic [3:0] d,
                       input bit ccu, input bit ccs);
    I_IssueValid = iv;
    I_Src1Used = s1u; I_Src1Idx = s1;
    I_Src2Used = s2u; I_Src2Idx = s2;
    I_DestValid = dv; I_DestIdx = d;
    I_CCUsed = ccu;   I_CCSet = ccs;
  endtask

  task automatic set_wb(input int p, input bit en, input logic [3:0] idx,
                        input logic [31:0] data, input bit scc);
    wb[p].en = en; wb[p].idx = idx; wb[p].data = data; wb[p].set_cc = scc;
  endtask

  task automatic idle();
    drive(0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0);
    for (int p = 0; p < NW; p++) set_wb(p, 0, 4'd0, 32'd0, 0);
  endtask

  // Check the stall for the inputs now driven, queue the expected operands
  // if the issue should be accepted, then advance one clock.
  task automatic cyc(input string tag, input bit stall,
                     input logic [31:0] e1, input logic [31:0] e2);
    exp_t e;
    #1;
    chk(tag, O_DepStall, stall);
    if (I_LOCK && I_IssueValid && !stall) begin
      e.s1 = e1; e.s2 = e2;
      exp_q.push_back(e);
    end
    @(posedge I_CLOCK);
    #1;
    idle();
  endtask

  // Output monitor: O_Valid must follow the queue, and values must match
  always @(posedge I_CLOCK) begin
    #1;
    if (mon_en && !I_RESET) begin
      chk("o_valid", O_Valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("o_src1", O_Src1Value, mon_e.s1);
        chk("o_src2", O_Src2Value, mon_e.s2);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    I_RESET = 1'b1;
    I_LOCK  = 1'b1;
    idle();
    repeat (2) @(posedge I_CLOCK);
    #1;
    chk("rst_valid", O_Valid, 1'b0);
    chk("rst_src1", O_Src1Value, 32'd0);
    chk("rst_src2", O_Src2Value, 32'd0);
    chk("rst_cc", O_CC, 3'b000);
    chk("rst_err", O_WbError, 1'b0);
    @(negedge I_CLOCK);
    I_RESET = 1'b0;
    mon_en  = 1'b1;

    // Plain read with nothing pending
    drive(1, 1, 4'd3, 1, 4'd4, 0, 4'd0, 0, 0); cyc("r3r4_nostall", 0, 0, 0);

    // RAW on R5, resolved by a same-cycle writeback on port 1
    drive(1, 0, 4'd0, 0, 4'd0, 1, 4'd5, 0, 0); cyc("claim_r5", 0, 0, 0);
    drive(1, 1, 4'd5, 0, 4'd0, 0, 4'd0, 0, 0); cyc("raw_r5_stall", 1, 0, 0);
    drive(1, 1, 4'd5, 0, 4'd0, 0, 4'd0, 0, 0);
    set_wb(1, 1, 4'd5, 32'h1234, 0);           cyc("raw_r5_bypass", 0, 32'h1234, 0);
    drive(1, 1, 4'd5, 1, 4'd5, 0, 4'd0, 0, 0); cyc("r5_drained", 0, 32'h1234, 32'h1234);

    // Fill R2 to the pending limit, then a fourth claim must stall
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 4'd0, 0, 4'd0, 1, 4'd2, 0, 0); cyc("claim_r2", 0, 0, 0);
    end
    drive(1, 0, 4'd0, 0, 4'd0, 1, 4'd2, 0, 0); cyc("r2_full_stall", 1, 0, 0);
    set_wb(0, 1, 4'd2, 32'hA, 0);
    set_wb(1, 1, 4'd2, 32'hB, 0);              cyc("dual_wb_r2", 0, 0, 0);
    drive(1, 1, 4'd2, 0, 4'd0, 0, 4'd0, 0, 0); cyc("r2_pend1_stall", 1, 0, 0);
    // Unused source still reads the RF: port 1 must have won the dual write
    drive(1, 0, 4'd2, 0, 4'd0, 0, 4'd0, 0, 0); cyc("r2_rf_peek", 0, 32'hB, 0);
    drive(1, 1, 4'd2, 0, 4'd0, 0, 4'd0, 0, 0);
    set_wb(0, 1, 4'd2, 32'hC, 0);              cyc("r2_last_wb", 0, 32'hC, 0);

    // Claim and writeback of R9 in the same cycle cancel out
    drive(1, 0, 4'd0, 0, 4'd0, 1, 4'd9, 0, 0); cyc("claim_r9", 0, 0, 0);
    drive(1, 0, 4'd0, 0, 4'd0, 1, 4'd9, 0, 0);
    set_wb(0, 1, 4'd9, 32'h99, 0);             cyc("r9_net", 0, 0, 0);
    drive(1, 1, 4'd9, 0, 4'd0, 0, 4'd0, 0, 0); cyc("r9_still_pend", 1, 0, 0);
    drive(1, 1, 4'd9, 0, 4'd0, 0, 4'd0, 0, 0);
    set_wb(1, 1, 4'd9, 32'h9A, 0);             cyc("r9_bypass", 0, 32'h9A, 0);
    drive(1, 1, 4'd9, 0, 4'd0, 0, 4'd0, 0, 0); cyc("r9_drained", 0, 32'h9A, 0);

    // Condition code: branch waits for the CC-setting writeback
    drive(1, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 1); cyc("ccset_issue", 0, 0, 0);
    drive(1, 0, 4'd0, 0, 4'd0, 0, 4'd0, 1, 0); cyc("branch_stall", 1, 0, 0);
    drive(1, 0, 4'd0, 0, 4'd0, 0, 4'd0, 1, 0);
    set_wb(0, 0, 4'd0, 32'hFFFF_FFFF, 1);      cyc("branch_bypass", 0, 0, 0);
    chk("cc_neg", O_CC, 3'b100);
    drive(1, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 1); cyc("ccset_issue2", 0, 0, 0);
    set_wb(1, 0, 4'd0, 32'd0, 1);              cyc("cc_wb_zero", 0, 0, 0);
    chk("cc_zero", O_CC, 3'b010);
    drive(1, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 1);
    set_wb(0, 0, 4'd0, 32'd5, 1);              cyc("ccset_net", 0, 0, 0);
    chk("cc_pos", O_CC, 3'b001);
    drive(1, 0, 4'd0, 0, 4'd0, 0, 4'd0, 1, 0); cyc("branch_ready", 0, 0, 0);
    chk("no_err_yet", O_WbError, 1'b0);

    // Issue is ignored while unlocked: no claim on R6
    I_LOCK = 1'b0;
    drive(1, 0, 4'd0, 0, 4'd0, 1, 4'd6, 0, 0); cyc("unlocked", 0, 0, 0);
    I_LOCK = 1'b1;
    drive(1, 1, 4'd6, 0, 4'd0, 0, 4'd0, 0, 0); cyc("r6_unclaimed", 0, 0, 0);

    // Writeback with nothing pending: data lands, error is sticky
    set_wb(0, 1, 4'd7, 32'h77, 0);             cyc("stray_wb_r7", 0, 0, 0);
    chk("err_set", O_WbError, 1'b1);
    drive(1, 1, 4'd7, 1, 4'd2, 0, 4'd0, 0, 0); cyc("r7_read", 0, 32'h77, 32'hC);
    chk("err_sticky", O_WbError, 1'b1);

    // Asynchronous reset while R1 is pending
    drive(1, 1, 4'd7, 1, 4'd2, 1, 4'd1, 0, 0); cyc("claim_r1", 0, 32'h77, 32'hC);
    #2;
    I_RESET = 1'b1;
    exp_q.delete();
    #1;
    chk("arst_valid", O_Valid, 1'b0);
    chk("arst_src1", O_Src1Value, 32'd0);
    chk("arst_src2", O_Src2Value, 32'd0);
    chk("arst_cc", O_CC, 3'b000);
    chk("arst_err", O_WbError, 1'b0);
    @(negedge I_CLOCK);
    I_RESET = 1'b0;
    drive(1, 1, 4'd1, 0, 4'd0, 0, 4'd0, 0, 0); cyc("r1_after_rst", 0, 0, 0);
    set_wb(1, 1, 4'd1, 32'h11, 0);             cyc("late_wb_r1", 0, 0, 0);
    chk("late_wb_err", O_WbError, 1'b1);

    @(posedge I_CLOCK);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
